fpu_round_pack: RTL and testbench
=================================

// Module: fpu_round_pack
// PURPOSE
//  Final stage after the fused multiply-add datapath: normalises the unpacked {sign, exp, frac} result,
//  rounds to IEEE-754 single, and packs a 32-bit word. Generates SH4-style exception cause bits and
//  accumulates them into sticky flags. Two-stage pipeline, stallable, carries the writeback tag.
// PARAMETERS
//  TAG_W   5             width of the tag carried alongside each operation
//  EXP_W   11            width of the signed, unbiased input exponent
//  FRAC_W  25            width of the input significand: units bit, 23 fraction bits, guard bit
//  QNAN    32'h7FBFFFFF  canonical quiet NaN emitted for every NaN result
// PORTS
//  clk       in   1       clock
//  rst_n     in   1       reset; asynchronous, active-low
//  i_en      in   1       pipeline advance enable; 0 = every pipeline register holds
//  i_valid   in   1       input operation valid (sampled only when i_en=1)
//  i_tag     in   TAG_W   operation tag
//  i_sign    in   1       result sign
//  i_exp     in   EXP_W   signed two's-complement unbiased exponent
//  i_frac    in   FRAC_W  [24]=units, [23:1]=fraction, [0]=guard
//  i_sticky  in   1       OR of all discarded bits below the guard bit
//  i_is_zero/i_is_inf/i_is_nan  in  1 each  special-value class of the input
//  i_invalid in   1       invalid-operation indication from upstream
//  i_rm      in   1       rounding mode: 0 = round-nearest-even, 1 = round-to-zero
//  i_dn      in   1       1 = flush denormal results to signed zero
//  flag_clr  in   1       synchronous clear of o_flags
//  o_valid   out  1       result valid
//  o_tag     out  TAG_W   tag of the result
//  o_result  out  32      packed single-precision result
//  o_cause   out  5       per-op causes {V,Z,O,U,I}; Z is always 0
//  o_flags   out  5       sticky OR of o_cause across all valid results
// BEHAVIOUR
//  - Reset: o_valid, o_tag, o_result, o_cause, o_flags and both internal valid bits are 0.
//    Asserting rst_n low mid-operation discards in-flight operations immediately.
//  - Latency: exactly 2 advancing (i_en=1) cycles from i_valid to o_valid. Throughput is 1 per cycle.
//    With i_en=0, o_* and all internal state hold unchanged; o_valid holds its value.
//  - S1, normalise: value = i_frac * 2^(i_exp-24).
//    * If i_frac[24]=0 and i_frac!=0, leading-zero count lz (1..24): shift left by lz, i_exp-=lz, shift in 0s.
//    * If i_frac==0 with no special flag set: exact zero, result +0 (sign forced to 0).
//  - S2, range, round and pack: biased E = exp+127, held in 12 bits signed.
//    * Normal (E>=1): significand sig=frac[24:1], guard g=frac[0], sticky s=i_sticky.
//    * Tiny (E<=0), i_dn=0: shift {sig,g} right by 1-E (saturate at 26); shifted-out bits OR into s; exp field 0.
//    * Tiny (E<=0), i_dn=1: result {sign,31'b0}; cause U|I.
//    * RN rounding: increment when g & (sig[0] | s). RZ rounding: never increment.
//    * Inexact I = g|s.
//    * Mantissa carry-out: exp field +1 and mantissa 0; a denormal that carries becomes exp field 1.
//    * Overflow (E>=255 after rounding): cause O|I; RN gives {sign,8'hFF,23'h0}; RZ gives {sign,32'h7F7FFFFF[30:0]}.
//    * U is set when the result is tiny AND inexact; exact denormals raise no flags.
//  - Special-value priority: nan > inf > zero > numeric.
//    * nan -> QNAN. inf -> {sign,8'hFF,0}. zero -> {sign,31'b0}. Special values raise no O/U/I.
//    * V = i_invalid, carried through the pipeline with the operation.
//  - o_cause updates only on an advancing cycle that produces o_valid=1; otherwise it holds.
//  - o_flags: on an advancing valid output, next = (flag_clr ? 0 : o_flags) | cause; otherwise
//    next = flag_clr ? 0 : o_flags. A simultaneous clear and new cause therefore leaves the new cause set.
// STRUCTURE
//  - Shared package fpu_pkg: QNAN, bias 127, RM_RN/RM_RZ encodings, cause bit indices (V=4,Z=3,O=2,U=1,I=0).
//  - One sub-module fpu_lzc25: combinational 25-bit leading-zero counter returning lz[4:0], used in S1.
//  - Everything else stays inline: two register banks, each gated by i_en and cleared by rst_n.
// TESTING
//  1 exp=0, frac=25'h1000000, RN -> o_result 32'h3F800000, cause 0, o_valid exactly 2 cycles after input.
//  2 exp=0, frac=25'h1FFFFFF -> RN: 32'h40000000, cause I. RZ: 32'h3FFFFFFF, cause I.
//  3 exp=200, frac=25'h1000000 -> RN: 32'h7F800000, cause O|I. RZ: 32'h7F7FFFFF, cause O|I.
//  4 exp=-130, frac=25'h1000000 -> dn=0: 32'h00080000, cause 0. dn=1: 32'h00000000, cause U|I.
//  5 exp=5, frac=25'h0000100 (cancellation) -> lz=16, value 2^-11 -> 32'h3A000000.
//    i_is_nan=1 with i_invalid=1 -> 32'h7FBFFFFF, cause V.
//  6 back-to-back ops with i_en low for 3 cycles mid-flight -> outputs hold, then drain in order.
//    flag_clr with a simultaneous I cause -> o_flags=5'h01. rst_n low mid-flight -> o_valid 0 at once.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants for the FPU writeback path: canonical NaN, exponent bias,
// rounding-mode encoding and the bit positions of the SH4-style cause vector.
package fpu_pkg;

  localparam logic [31:0] QNAN_DEFAULT = 32'h7FBFFFFF;
  localparam int          BIAS         = 127;
  localparam int          SHIFT_SAT    = 26;

  typedef enum logic {
    RM_RN = 1'b0,
    RM_RZ = 1'b1
  } rm_e;

  localparam int CAUSE_V = 4;
  localparam int CAUSE_Z = 3;
  localparam int CAUSE_O = 2;
  localparam int CAUSE_U = 1;
  localparam int CAUSE_I = 0;

  function automatic logic [31:0] packSingle(input logic sign, input logic [7:0] expField,
                                             input logic [22:0] mant);
    return {sign, expField, mant};
  endfunction

endpackage

// File: rtl/fpu_round_pack_if.sv
// Operation and result bundle between the FMA datapath and the round/pack stage.
// The master drives the operation; the slave (round/pack) returns the packed result.
interface fpu_round_pack_if #(
  parameter int TAG_W  = 5,
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 25
);

  logic              i_en;
  logic              i_valid;
  logic [TAG_W-1:0]  i_tag;
  logic              i_sign;
  logic [EXP_W-1:0]  i_exp;
  logic [FRAC_W-1:0] i_frac;
  logic              i_sticky;
  logic              i_is_zero;
  logic              i_is_inf;
  logic              i_is_nan;
  logic              i_invalid;
  logic              i_rm;
  logic              i_dn;
  logic              flag_clr;

  logic              o_valid;
  logic [TAG_W-1:0]  o_tag;
  logic [31:0]       o_result;
  logic [4:0]        o_cause;
  logic [4:0]        o_flags;

  modport master (
    output i_en, i_valid, i_tag, i_sign, i_exp, i_frac, i_sticky,
           i_is_zero, i_is_inf, i_is_nan, i_invalid, i_rm, i_dn, flag_clr,
    input  o_valid, o_tag, o_result, o_cause, o_flags
  );

  modport slave (
    input  i_en, i_valid, i_tag, i_sign, i_exp, i_frac, i_sticky,
           i_is_zero, i_is_inf, i_is_nan, i_invalid, i_rm, i_dn, flag_clr,
    output o_valid, o_tag, o_result, o_cause, o_flags
  );

endinterface

// File: rtl/fpu_lzc25.sv
// Combinational leading-zero counter for the 25-bit unpacked significand.
// An all-zero input reports 25 so that the normalising shift clears the value.
module fpu_lzc25 (
  input  logic [24:0] i_frac,
  output logic [4:0]  o_lz
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_lz = 5'd25;
    for (int k = 0; k < 25; k++) begin
      if (i_frac[k]) o_lz = 5'(24 - k);
    end
  end

endmodule

// File: rtl/fpu_round_pack.sv
// Two-stage normalise / round / pack for IEEE-754 single results, with SH4-style
// cause bits and sticky flags. Both stages stall together when i_en is low.
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter int          TAG_W  = 5,
  parameter int          EXP_W  = 11,
  parameter int          FRAC_W = 25,
  parameter logic [31:0] QNAN   = QNAN_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  fpu_round_pack_if.slave bus
);

  localparam int EW = 12;

  logic [4:0]           w_lz;
  logic                 w_fracZero;
  logic                 w_special;
  logic [FRAC_W-1:0]    w_normFrac;
  logic signed [EW-1:0] w_expExt;
  logic signed [EW-1:0] w_normExp;

  logic                 r1_valid;
  logic [TAG_W-1:0]     r1_tag;
  logic                 r1_sign;
  logic signed [EW-1:0] r1_exp;
  logic [FRAC_W-1:0]    r1_frac;
  logic                 r1_sticky;
  logic                 r1_isNan;
  logic                 r1_isInf;
  logic                 r1_isZero;
  logic                 r1_invalid;
  rm_e                  r1_rm;
  logic                 r1_dn;

  fpu_lzc25 u_lzc (
    .i_frac (bus.i_frac),
    .o_lz   (w_lz)
  );

  assign w_fracZero = (bus.i_frac == '0);
  assign w_special  = bus.i_is_nan | bus.i_is_inf | bus.i_is_zero;
  assign w_normFrac = bus.i_frac << w_lz;
  assign w_expExt   = {{(EW-EXP_W){bus.i_exp[EXP_W-1]}}, bus.i_exp};
  assign w_normExp  = w_expExt - signed'({7'd0, w_lz});

  // Stage 1 captures the normalised operand; a plain zero significand becomes +0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_tag     <= '0;
      r1_sign    <= 1'b0;
      r1_exp     <= '0;
      r1_frac    <= '0;
      r1_sticky  <= 1'b0;
      r1_isNan   <= 1'b0;
      r1_isInf   <= 1'b0;
      r1_isZero  <= 1'b0;
      r1_invalid <= 1'b0;
      r1_rm      <= RM_RN;
      r1_dn      <= 1'b0;
    end else if (bus.i_en) begin
      r1_valid   <= bus.i_valid;
      r1_tag     <= bus.i_tag;
      r1_sign    <= (w_fracZero && !w_special) ? 1'b0 : bus.i_sign;
      r1_exp     <= w_normExp;
      r1_frac    <= w_normFrac;
      r1_sticky  <= bus.i_sticky;
      r1_isNan   <= bus.i_is_nan;
      r1_isInf   <= bus.i_is_inf;
      r1_isZero  <= bus.i_is_zero | (w_fracZero & !w_special);
      r1_invalid <= bus.i_invalid;
      r1_rm      <= rm_e'(bus.i_rm);
      r1_dn      <= bus.i_dn;
    end
  end

  logic signed [EW-1:0] w_biasE;
  logic                 w_tiny;
  logic signed [EW-1:0] w_shRaw;
  logic [4:0]           w_sh;
  logic [50:0]          w_shWide;
  logic [23:0]          w_sig;
  logic                 w_guard;
  logic                 w_stk;
  logic                 w_inc;
  logic [24:0]          w_sum;
  logic signed [EW-1:0] w_expN;
  logic                 w_ovf;
  logic                 w_inexact;
  logic [31:0]          w_result;
  logic [4:0]           w_cause;

  assign w_biasE   = r1_exp + 12'sd127;
  assign w_tiny    = (w_biasE < 12'sd1);
  assign w_shRaw   = 12'sd1 - w_biasE;
  assign w_sh      = (w_shRaw > 12'(SHIFT_SAT)) ? 5'(SHIFT_SAT) : w_shRaw[4:0];
  // 26 zero bits below the operand keep every shifted-out bit for the sticky OR.
  assign w_shWide  = {r1_frac, 26'd0} >> w_sh;
  assign w_sig     = w_tiny ? w_shWide[50:27] : r1_frac[24:1];
  assign w_guard   = w_tiny ? w_shWide[26] : r1_frac[0];
  assign w_stk     = r1_sticky | (w_tiny & (|w_shWide[25:0]));
  assign w_inc     = (r1_rm == RM_RN) & w_guard & (w_sig[0] | w_stk);
  assign w_sum     = {1'b0, w_sig} + {24'd0, w_inc};
  assign w_expN    = w_biasE + 12'(w_sum[24]);
  assign w_ovf     = !w_tiny && (w_expN >= 12'sd255);
  assign w_inexact = w_guard | w_stk;

  // Special classes win over numeric results and never raise O/U/I.
  always_comb begin
    w_result          = '0;
    w_cause           = '0;
    w_cause[CAUSE_V]  = r1_invalid;
    w_cause[CAUSE_Z]  = 1'b0;
    if (r1_isNan) begin
      w_result = QNAN;
    end else if (r1_isInf) begin
      w_result = packSingle(r1_sign, 8'hFF, 23'd0);
    end else if (r1_isZero) begin
      w_result = packSingle(r1_sign, 8'h00, 23'd0);
    end else if (w_tiny && r1_dn) begin
      w_result         = packSingle(r1_sign, 8'h00, 23'd0);
      w_cause[CAUSE_U] = 1'b1;
      w_cause[CAUSE_I] = 1'b1;
    end else if (w_ovf) begin
      w_result         = (r1_rm == RM_RN) ? packSingle(r1_sign, 8'hFF, 23'd0)
                                          : packSingle(r1_sign, 8'hFE, 23'h7FFFFF);
      w_cause[CAUSE_O] = 1'b1;
      w_cause[CAUSE_I] = 1'b1;
    end else if (w_tiny) begin
      w_result         = packSingle(r1_sign, {7'd0, w_sum[23]}, w_sum[22:0]);
      w_cause[CAUSE_U] = w_inexact;
      w_cause[CAUSE_I] = w_inexact;
    end else begin
      w_result         = packSingle(r1_sign, w_expN[7:0], w_sum[22:0]);
      w_cause[CAUSE_I] = w_inexact;
    end
  end

  logic             r2_valid;
  logic [TAG_W-1:0] r2_tag;
  logic [31:0]      r2_result;
  logic [4:0]       r2_cause;
  logic [4:0]       r2_flags;

  // The flag clear acts even while stalled; a new cause on the same edge survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_tag    <= '0;
      r2_result <= '0;
      r2_cause  <= '0;
      r2_flags  <= '0;
    end else begin
      if (bus.i_en) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_tag    <= r1_tag;
          r2_result <= w_result;
          r2_cause  <= w_cause;
        end
      end
      if (bus.i_en && r1_valid) begin
        r2_flags <= (bus.flag_clr ? 5'd0 : r2_flags) | w_cause;
      end else if (bus.flag_clr) begin
        r2_flags <= 5'd0;
      end
    end
  end

  assign bus.o_valid  = r2_valid;
  assign bus.o_tag    = r2_tag;
  assign bus.o_result = r2_result;
  assign bus.o_cause  = r2_cause;
  assign bus.o_flags  = r2_flags;

endmodule

// File: tb/tb_fpu_round_pack.sv
// Directed bench for fpu_round_pack: expected results are queued when an operation
// is driven and popped when the DUT presents a result after an advancing edge.
module tb_fpu_round_pack;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] result;
    logic [4:0]  cause;
  } exp_t;

  exp_t sb[$];

  fpu_round_pack_if #(.TAG_W(5), .EXP_W(11), .FRAC_W(25)) bus ();

  fpu_round_pack #(
    .TAG_W  (5),
    .EXP_W  (11),
    .FRAC_W (25),
    .QNAN   (32'h7FBFFFFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // A result is new only when the edge that produced it had i_en high.
  task automatic checkOutput();
    exp_t e;
    if (bus.i_en && bus.o_valid) begin
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("[TB] FAIL unexpected_output observed tag=%0d expected no result", bus.o_tag);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkValue("tag", 32'(bus.o_tag), 32'(e.tag));
        checkValue("result", bus.o_result, e.result);
        checkValue("cause", 32'(bus.o_cause), 32'(e.cause));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [4:0] tag, input logic sgn, input logic [10:0] ex,
                               input logic [24:0] frac, input logic stk, input logic [2:0] cls,
                               input logic inv, input logic rm, input logic dn,
                               input logic [31:0] expResult, input logic [4:0] expCause);
    exp_t e;
    bus.i_en      = 1'b1;
    bus.i_valid   = 1'b1;
    bus.i_tag     = tag;
    bus.i_sign    = sgn;
    bus.i_exp     = ex;
    bus.i_frac    = frac;
    bus.i_sticky  = stk;
    bus.i_is_nan  = cls[2];
    bus.i_is_inf  = cls[1];
    bus.i_is_zero = cls[0];
    bus.i_invalid = inv;
    bus.i_rm      = rm;
    bus.i_dn      = dn;
    e.tag = tag;
    e.result = expResult;
    e.cause = expCause;
    sb.push_back(e);
    tick();
  endtask

  task automatic applyIdle();
    bus.i_en    = 1'b1;
    bus.i_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_en = 1'b0; bus.i_valid = 1'b0; bus.i_tag = '0; bus.i_sign = 1'b0;
    bus.i_exp = '0; bus.i_frac = '0; bus.i_sticky = 1'b0; bus.i_is_zero = 1'b0;
    bus.i_is_inf = 1'b0; bus.i_is_nan = 1'b0; bus.i_invalid = 1'b0;
    bus.i_rm = 1'b0; bus.i_dn = 1'b0; bus.flag_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("rst_valid", 32'(bus.o_valid), 32'h0);
    checkValue("rst_tag", 32'(bus.o_tag), 32'h0);
    checkValue("rst_result", bus.o_result, 32'h0);
    checkValue("rst_cause", 32'(bus.o_cause), 32'h0);
    checkValue("rst_flags", 32'(bus.o_flags), 32'h0);
    rst_n = 1'b1;

    // 1.0 exactly, and the two-edge latency from an empty pipeline.
    applyStimulus(5'd1, 1'b0, 11'd0, 25'h1000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 5'h00);
    checkValue("latency_edge1_valid", 32'(bus.o_valid), 32'h0);
    applyIdle();
    checkValue("latency_edge2_valid", 32'(bus.o_valid), 32'h1);
    checkValue("flags_after_exact", 32'(bus.o_flags), 32'h0);

    // Back-to-back stream of rounding, range and special-value cases.
    applyStimulus(5'd2,  1'b0, 11'd0,         25'h1FFFFFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'h01);
    applyStimulus(5'd3,  1'b0, 11'd0,         25'h1FFFFFF, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h3FFFFFFF, 5'h01);
    applyStimulus(5'd4,  1'b0, 11'd200,       25'h1000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 5'h05);
    applyStimulus(5'd5,  1'b0, 11'd200,       25'h1000000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h7F7FFFFF, 5'h05);
    applyStimulus(5'd6,  1'b0, 11'(-130),     25'h1000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h00080000, 5'h00);
    applyStimulus(5'd7,  1'b0, 11'(-130),     25'h1000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h00000000, 5'h03);
    applyStimulus(5'd8,  1'b0, 11'd5,         25'h0000100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h3A000000, 5'h00);
    applyStimulus(5'd9,  1'b0, 11'd0,         25'h1000000, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 32'h7FBFFFFF, 5'h10);
    applyStimulus(5'd10, 1'b1, 11'd3,         25'h0000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h00000000, 5'h00);
    applyStimulus(5'd11, 1'b1, 11'd0,         25'h1000000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFF800000, 5'h00);
    applyStimulus(5'd12, 1'b1, 11'd0,         25'h1000000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h80000000, 5'h00);
    applyStimulus(5'd13, 1'b0, 11'(-127),     25'h1FFFFFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h00800000, 5'h03);
    applyStimulus(5'd14, 1'b0, 11'd0,         25'h1000001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 5'h01);
    applyStimulus(5'd15, 1'b0, 11'd0,         25'h1000001, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h3F800001, 5'h01);
    applyIdle();
    applyIdle();
    checkValue("flags_accumulated", 32'(bus.o_flags), 32'h17);

    // Stall three cycles with B at the output and C in stage 1.
    applyStimulus(5'd16, 1'b0, 11'd0,   25'h1FFFFFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'h01);
    applyStimulus(5'd17, 1'b0, 11'd200, 25'h1000000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h7F7FFFFF, 5'h05);
    applyStimulus(5'd18, 1'b0, 11'd5,   25'h0000100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h3A000000, 5'h00);
    for (int i = 0; i < 3; i++) begin
      bus.i_en    = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_tag   = 5'd31;
      tick();
      checkValue("stall_valid", 32'(bus.o_valid), 32'h1);
      checkValue("stall_tag", 32'(bus.o_tag), 32'd17);
      checkValue("stall_result", bus.o_result, 32'h7F7FFFFF);
    end
    applyIdle();
    applyIdle();
    checkValue("drained_valid", 32'(bus.o_valid), 32'h0);

    // Clear coinciding with a new inexact cause keeps only that cause.
    applyStimulus(5'd19, 1'b0, 11'd0, 25'h1FFFFFF, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h3FFFFFFF, 5'h01);
    bus.flag_clr = 1'b1;
    applyIdle();
    checkValue("flags_clr_with_cause", 32'(bus.o_flags), 32'h01);
    applyIdle();
    checkValue("flags_clr_idle", 32'(bus.o_flags), 32'h00);
    bus.flag_clr = 1'b0;

    // Asynchronous reset with one result at the output and one in flight.
    applyStimulus(5'd20, 1'b0, 11'd0, 25'h1FFFFFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'h01);
    applyStimulus(5'd21, 1'b0, 11'd5, 25'h0000100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h3A000000, 5'h00);
    checkValue("pre_reset_valid", 32'(bus.o_valid), 32'h1);
    checkValue("pre_reset_flags", 32'(bus.o_flags), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async_rst_valid", 32'(bus.o_valid), 32'h0);
    checkValue("async_rst_result", bus.o_result, 32'h0);
    checkValue("async_rst_flags", 32'(bus.o_flags), 32'h0);
    sb.delete();
    bus.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyIdle();
    checkValue("post_rst_valid1", 32'(bus.o_valid), 32'h0);
    applyIdle();
    checkValue("post_rst_valid2", 32'(bus.o_valid), 32'h0);

    checkValue("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
